// File: rtl/prim_rr_onehot_arb.sv
// Round-robin arbiter with one-hot grant, AND-OR data select and a single-entry valid/ready output slot.
// Optional burst lock (adds lock_i) is enabled by defining PRIM_RR_ARB_LOCK_EN.
module prim_rr_onehot_arb #(
  parameter int Inputs = 8,
  parameter int Width  = 32,
  localparam int IdxW  = (Inputs > 1) ? $clog2(Inputs) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [Inputs-1:0]         req_i,
  input  logic [Inputs*Width-1:0]   data_i,
`ifdef PRIM_RR_ARB_LOCK_EN
  input  logic [Inputs-1:0]         lock_i,
`endif
  output logic [Inputs-1:0]         gnt_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [Width-1:0]          data_o,
  output logic [IdxW-1:0]           idx_o
);

  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   win;
  logic [IdxW-1:0]   ptr_nxt;
  logic              found;
  logic              accept;
  logic              xfer;
  logic [Width-1:0]  data_sel;

  assign accept = !valid_o || ready_i;

  // Scan from ptr_q upward with wrap; the first requester seen wins.
  always_comb begin
    int j;
    j     = 0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < Inputs; i++) begin
      j = int'(ptr_q) + i;
      if (j >= Inputs) j = j - Inputs;
      if (!found && req_i[j[IdxW-1:0]]) begin
        found = 1'b1;
        win   = j[IdxW-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (rst_ni && accept && found) gnt_o[win] = 1'b1;
  end

  assign xfer = |gnt_o;

  // Requester 0 sits at the MSB end of data_i.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < Inputs; i++) begin
      data_sel = data_sel | ({Width{gnt_o[i]}} & data_i[(Inputs-1-i)*Width +: Width]);
    end
  end

  always_comb begin
    if (win == IdxW'(Inputs - 1)) ptr_nxt = '0;
    else                          ptr_nxt = win + 1'b1;
`ifdef PRIM_RR_ARB_LOCK_EN
    if (lock_i[win]) ptr_nxt = win;
`endif
  end

  // Output slot and priority pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      idx_o   <= '0;
      ptr_q   <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= data_sel;
      idx_o   <= win;
      ptr_q   <= ptr_nxt;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prim_rr_onehot_arb.sv
// Directed bench for prim_rr_onehot_arb: reset, rotation, sparse wrap, backpressure, mid-stream reset, lock.
module tb_prim_rr_onehot_arb;

  localparam int N = 8;
  localparam int W = 32;

  logic            clk;
  logic            rst_ni;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data;
  logic [N-1:0]    gnt;
  logic            valid;
  logic            ready;
  logic [W-1:0]    dout;
  logic [2:0]      idx;
`ifdef PRIM_RR_ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif

  int tests = 0;
  int fails = 0;

  prim_rr_onehot_arb #(.Inputs(N), .Width(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .req_i   (req),
    .data_i  (data),
`ifdef PRIM_RR_ARB_LOCK_EN
    .lock_i  (lock),
`endif
    .gnt_o   (gnt),
    .valid_o (valid),
    .ready_i (ready),
    .data_o  (dout),
    .idx_o   (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(int i);
    return 32'hA5A5_0000 | W'(i);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, check combinational grant, clock, then check the registered slot.
  task automatic xfer_step(string tag, logic [N-1:0] r, int exp_idx);
    req = r;
    #1;
    check({tag, "_gnt"}, 32'(gnt), 32'(1) << exp_idx);
    cyc();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_idx"}, 32'(idx), 32'(exp_idx));
    check({tag, "_data"}, dout, word(exp_idx));
  endtask

  initial begin
    for (int i = 0; i < N; i++) data[(N-1-i)*W +: W] = word(i);
    rst_ni = 1'b0;
    req    = 8'hFF;
    ready  = 1'b1;
`ifdef PRIM_RR_ARB_LOCK_EN
    lock   = '0;
`endif
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_data", dout, 32'd0);
    cyc();
    cyc();
    check("rst_hold_gnt", 32'(gnt), 32'd0);
    rst_ni = 1'b1;

    // first transfer after reset goes to requester 0
    xfer_step("first", 8'hFF, 0);

    // fair rotation, ptr ends at 7
    for (int k = 1; k <= 22; k++) xfer_step("rot", 8'hFF, k % N);

    // sparse wrap from ptr 7
    xfer_step("sparse0", 8'h44, 2);
    xfer_step("sparse1", 8'h44, 6);
    xfer_step("sparse2", 8'h44, 2);

    // backpressure with ptr 3
    req   = 8'h0F;
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_gnt", 32'(gnt), 32'd0);
      cyc();
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_idx", 32'(idx), 32'd2);
      check("bp_data", dout, word(2));
    end
    ready = 1'b1;
    xfer_step("bp_release", 8'h0F, 3);
    xfer_step("bp_wrap", 8'h0F, 0);

    // drain with no new request
    req = '0;
    #1;
    check("drain_gnt", 32'(gnt), 32'd0);
    cyc();
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_idx", 32'(idx), 32'd0);
    check("drain_data", dout, word(0));

    // mid-stream reset while slot holds requester 5
    xfer_step("pre_rst", 8'h20, 5);
    ready = 1'b0;
    req   = 8'hFF;
    #3;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_idx", 32'(idx), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    cyc();
    rst_ni = 1'b1;
    ready  = 1'b1;
    xfer_step("post_rst", 8'hFF, 0);

`ifdef PRIM_RR_ARB_LOCK_EN
    // burst lock on requester 2, ptr starts at 1
    lock = 8'h04;
    xfer_step("lock0", 8'h0C, 2);
    xfer_step("lock1", 8'h0C, 2);
    xfer_step("lock2", 8'h0C, 2);
    lock = 8'h00;
    xfer_step("unlock", 8'h0C, 2);
    xfer_step("after_lock", 8'h0C, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
